// File: rtl/proto_field_packer.sv
// Packs the raw bytes of a length-delimited field into little-endian 64-bit words and passes scalars through.
// Records go into a show-ahead FIFO with two write slots. Overflow drops the records and sets a sticky flag.
module proto_field_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIELD_W    = 5,
    parameter int DATA_W     = 64
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            in_valid_i,
    input  logic [FIELD_W-1:0]              in_field_num_i,
    input  logic [7:0]                      in_byte_sel_i,
    input  logic [DATA_W-1:0]               in_val_i,
    input  logic                            in_raw_byte_i,
    input  logic                            flush_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [FIELD_W-1:0]              out_field_num_o,
    output logic [7:0]                      out_byte_sel_o,
    output logic [DATA_W-1:0]               out_data_o,
    output logic                            out_last_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            overflow_o
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = FIELD_W + 8 + DATA_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PACKING = 1'b1;

    // Reset asserts asynchronously and is released on a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst_n;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync_reg <= 2'b00;
        else           rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_n = rst_sync_reg[1];

    logic [0:0]         state_reg, state_next;
    logic [FIELD_W-1:0] field_reg, field_next;
    logic [7:0]         sel_reg, sel_next;
    logic [DATA_W-1:0]  buf_reg, buf_next;
    logic [3:0]         cnt_reg, cnt_next;

    logic [DATA_W-1:0]  buf_ins;
    logic [7:0]         sel_ins;
    logic [DATA_W-1:0]  buf_new;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign buf_ins[gi*8 +: 8] = (cnt_reg[2:0] == 3'(gi)) ? in_val_i[7:0] : buf_reg[gi*8 +: 8];
            assign sel_ins[gi]        = sel_reg[gi] | (cnt_reg[2:0] == 3'(gi));
        end
    endgenerate
    assign buf_new = {{(DATA_W-8){1'b0}}, in_val_i[7:0]};

    logic             emit_old, old_last, emit_scalar, emit_flush;
    logic [REC_W-1:0] flush_rec, second_rec, rec_a, rec_b;
    logic [1:0]       n_enq;

    always_comb begin
        state_next  = state_reg;
        field_next  = field_reg;
        sel_next    = sel_reg;
        buf_next    = buf_reg;
        cnt_next    = cnt_reg;
        emit_old    = 1'b0;
        old_last    = 1'b1;
        emit_scalar = 1'b0;
        if (in_valid_i) begin
            if (!in_raw_byte_i) begin
                emit_old    = (state_reg == ST_PACKING);
                emit_scalar = 1'b1;
                state_next  = ST_IDLE;
                sel_next    = '0;
                buf_next    = '0;
                cnt_next    = '0;
            end else if (state_reg == ST_IDLE || in_field_num_i != field_reg) begin
                emit_old   = (state_reg == ST_PACKING);
                state_next = ST_PACKING;
                field_next = in_field_num_i;
                sel_next   = 8'h01;
                buf_next   = buf_new;
                cnt_next   = 4'd1;
            end else if (cnt_reg == 4'd8) begin
                // A full word is only released once another byte proves it is not the last one.
                emit_old = 1'b1;
                old_last = 1'b0;
                sel_next = 8'h01;
                buf_next = buf_new;
                cnt_next = 4'd1;
            end else begin
                sel_next = sel_ins;
                buf_next = buf_ins;
                cnt_next = cnt_reg + 4'd1;
            end
        end
        flush_rec  = {field_next, sel_next, buf_next, 1'b1};
        emit_flush = flush_i && (state_next == ST_PACKING);
        if (emit_flush) begin
            state_next = ST_IDLE;
            sel_next   = '0;
            buf_next   = '0;
            cnt_next   = '0;
        end
        second_rec = emit_scalar ? {in_field_num_i, in_byte_sel_i, in_val_i, 1'b1} : flush_rec;
        rec_a      = emit_old ? {field_reg, sel_reg, buf_reg, old_last} : second_rec;
        rec_b      = second_rec;
        n_enq      = 2'(emit_old) + 2'(emit_scalar | emit_flush);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            field_reg <= '0;
            sel_reg   <= '0;
            buf_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            field_reg <= field_next;
            sel_reg   <= sel_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
        end
    end

    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, free_slots;
    logic             overflow_reg, drop, pop;
    logic [1:0]       push_n;
    logic [REC_W-1:0] head_rec;

    // Free space is judged before this cycle's pop, so an overflow can never depend on the consumer.
    assign free_slots = DEPTH_C - count_reg;
    assign drop       = free_slots < CW'(n_enq);
    assign push_n     = drop ? 2'd0 : n_enq;
    assign pop        = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (push_n != 2'd0) mem[wr_ptr_reg] <= rec_a;
        if (push_n == 2'd2) mem[wr_ptr_reg + AW'(1)] <= rec_b;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_reg + AW'(push_n);
            rd_ptr_reg   <= rd_ptr_reg + AW'(pop);
            count_reg    <= count_reg + CW'(push_n) - CW'(pop);
            overflow_reg <= overflow_reg | drop;
        end
    end

    assign out_valid_o  = (count_reg != '0);
    assign head_rec     = out_valid_o ? mem[rd_ptr_reg] : '0;
    assign {out_field_num_o, out_byte_sel_o, out_data_o, out_last_o} = head_rec;
    assign fifo_count_o = count_reg;
    assign overflow_o   = overflow_reg;
endmodule

// File: tb/tb_proto_field_packer.sv
// Directed and randomized bench for proto_field_packer.
// The reference model keeps the open field as a byte queue and the FIFO as a record queue.
module tb_proto_field_packer;
    localparam int D  = 16;
    localparam int FW = 5;
    localparam int DW = 64;
    localparam int CW = $clog2(D) + 1;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [FW-1:0] in_field_num_i = '0;
    logic [7:0]    in_byte_sel_i = '0;
    logic [DW-1:0] in_val_i = '0;
    logic          in_raw_byte_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [FW-1:0] out_field_num_o;
    logic [7:0]    out_byte_sel_o;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic [CW-1:0] fifo_count_o;
    logic          overflow_o;

    always #5 clk_i = ~clk_i;

    proto_field_packer #(.FIFO_DEPTH(D), .FIELD_W(FW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .in_valid_i(in_valid_i),
        .in_field_num_i(in_field_num_i), .in_byte_sel_i(in_byte_sel_i), .in_val_i(in_val_i),
        .in_raw_byte_i(in_raw_byte_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_field_num_o(out_field_num_o), .out_byte_sel_o(out_byte_sel_o),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .fifo_count_o(fifo_count_o),
        .overflow_o(overflow_o)
    );

    typedef struct packed {
        logic [FW-1:0] f;
        logic [7:0]    sel;
        logic [DW-1:0] d;
        logic          last;
    } rec_t;

    rec_t          q[$];
    logic [7:0]    pend[$];
    logic [FW-1:0] pf = '0;
    bit            active = 1'b0;
    bit            ovf = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [FW-1:0] f, input logic [7:0] s, input logic [DW-1:0] d, input logic l);
        rec_t r;
        r.f = f; r.sel = s; r.d = d; r.last = l;
        return r;
    endfunction

    function automatic rec_t pend_rec(input bit last);
        rec_t r;
        r.f    = pf;
        r.sel  = 8'((9'd1 << pend.size()) - 9'd1);
        r.d    = '0;
        foreach (pend[i]) r.d[i*8 +: 8] = pend[i];
        r.last = last;
        return r;
    endfunction

    function automatic rec_t head();
        return {out_field_num_o, out_byte_sel_o, out_data_o, out_last_o};
    endfunction

    task automatic model_reset();
        q.delete(); pend.delete(); active = 1'b0; ovf = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [FW-1:0] f, input logic [7:0] s,
                              input logic [DW-1:0] val, input bit raw, input bit fl, input bit rdy);
        rec_t nl[$];
        if (v) begin
            if (!raw) begin
                if (active) nl.push_back(pend_rec(1'b1));
                pend.delete(); active = 1'b0;
                nl.push_back(mk(f, s, val, 1'b1));
            end else if (!active || f != pf) begin
                if (active) nl.push_back(pend_rec(1'b1));
                pend.delete(); pend.push_back(val[7:0]); pf = f; active = 1'b1;
            end else if (pend.size() == 8) begin
                nl.push_back(pend_rec(1'b0));
                pend.delete(); pend.push_back(val[7:0]);
            end else begin
                pend.push_back(val[7:0]);
            end
        end
        if (fl && active) begin
            nl.push_back(pend_rec(1'b1));
            pend.delete(); active = 1'b0;
        end
        if ((D - q.size()) < nl.size()) begin
            ovf = 1'b1;
            nl.delete();
        end
        if (q.size() != 0 && rdy) begin
            $display("txn pop field=%0d sel=%02h data=%016h last=%0d", q[0].f, q[0].sel, q[0].d, q[0].last);
            void'(q.pop_front());
        end
        foreach (nl[i]) q.push_back(nl[i]);
    endtask

    task automatic check_all();
        chk("out_valid", 128'(out_valid_o), 128'(q.size() != 0));
        chk("fifo_count", 128'(fifo_count_o), 128'(q.size()));
        chk("overflow", 128'(overflow_o), 128'(ovf));
        if (q.size() != 0) chk("head", 128'(head()), 128'(q[0]));
    endtask

    task automatic step(input bit v, input logic [FW-1:0] f, input logic [7:0] s,
                        input logic [DW-1:0] val, input bit raw, input bit fl, input bit rdy);
        in_valid_i = v; in_field_num_i = f; in_byte_sel_i = s; in_val_i = val;
        in_raw_byte_i = raw; flush_i = fl; out_ready_i = rdy;
        @(posedge clk_i);
        model_step(v, f, s, val, raw, fl, rdy);
        #1;
        check_all();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (3) idle(1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 128'(out_valid_o), 128'(0));
        chk("rst_count", 128'(fifo_count_o), 128'(0));
        chk("rst_ovf", 128'(overflow_o), 128'(0));
        chk("rst_head", 128'(head()), 128'(0));
        release_reset();

        // Scalar pass-through
        step(1'b1, 5'd3, 8'h01, 64'h96, 1'b0, 1'b0, 1'b1);
        chk("t1_head", 128'(head()), 128'(mk(5'd3, 8'h01, 64'h96, 1'b1)));
        idle(1'b1);
        chk("t1_count", 128'(fifo_count_o), 128'(0));

        // Three bytes then flush
        step(1'b1, 5'd2, 8'h00, 64'h61, 1'b1, 1'b0, 1'b1);
        step(1'b1, 5'd2, 8'h00, 64'h62, 1'b1, 1'b0, 1'b1);
        step(1'b1, 5'd2, 8'h00, 64'h63, 1'b1, 1'b0, 1'b1);
        chk("t2_nothing_yet", 128'(fifo_count_o), 128'(0));
        step(1'b0, 5'd0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b1);
        chk("t2_head", 128'(head()), 128'(mk(5'd2, 8'h07, 64'h636261, 1'b1)));
        idle(1'b1);

        // Ten bytes spanning a word, then a scalar
        for (int i = 0; i < 10; i++) step(1'b1, 5'd4, 8'h00, 64'(i), 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd5, 8'h01, 64'h7, 1'b0, 1'b0, 1'b0);
        chk("t3_count", 128'(fifo_count_o), 128'(3));
        chk("t3_rec0", 128'(head()), 128'(mk(5'd4, 8'hFF, 64'h0706050403020100, 1'b0)));
        idle(1'b1);
        chk("t3_rec1", 128'(head()), 128'(mk(5'd4, 8'h03, 64'h0908, 1'b1)));
        idle(1'b1);
        chk("t3_rec2", 128'(head()), 128'(mk(5'd5, 8'h01, 64'h7, 1'b1)));
        idle(1'b1);

        // Field change plus flush in one cycle: two enqueues
        step(1'b1, 5'd2, 8'h00, 64'hAA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'd6, 8'h00, 64'hBB, 1'b1, 1'b1, 1'b0);
        chk("t4_count", 128'(fifo_count_o), 128'(2));
        chk("t4_rec0", 128'(head()), 128'(mk(5'd2, 8'h01, 64'hAA, 1'b1)));
        idle(1'b1);
        chk("t4_rec1", 128'(head()), 128'(mk(5'd6, 8'h01, 64'hBB, 1'b1)));
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 8), 5'($urandom_range(1, 3)), 8'($urandom),
                 {$urandom, $urandom}, ($urandom_range(0, 9) < 7), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (20) idle(1'b1);

        // Overflow with a stalled consumer
        reset_ni = 1'b0;
        #1;
        model_reset();
        release_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 5'(i + 1), 8'hFF, 64'(100 + i), 1'b0, 1'b0, 1'b0);
        chk("t5_count", 128'(fifo_count_o), 128'(16));
        chk("t5_ovf", 128'(overflow_o), 128'(1));
        chk("t5_head", 128'(head()), 128'(mk(5'd1, 8'hFF, 64'd100, 1'b1)));
        repeat (3) idle(1'b0);
        chk("t5_head_stable", 128'(head()), 128'(mk(5'd1, 8'hFF, 64'd100, 1'b1)));
        repeat (18) idle(1'b1);
        chk("t5_ovf_sticky", 128'(overflow_o), 128'(1));

        // Asynchronous reset mid-field
        step(1'b1, 5'd9, 8'h01, 64'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 5'd7, 8'h00, 64'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("t6_valid", 128'(out_valid_o), 128'(0));
        chk("t6_count", 128'(fifo_count_o), 128'(0));
        chk("t6_ovf", 128'(overflow_o), 128'(0));
        model_reset();
        release_reset();
        step(1'b1, 5'd9, 8'h03, 64'h1234, 1'b0, 1'b0, 1'b0);
        chk("t6_head", 128'(head()), 128'(mk(5'd9, 8'h03, 64'h1234, 1'b1)));
        step(1'b0, 5'd0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b1);
        chk("t6_no_stale", 128'(fifo_count_o), 128'(0));
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
